// File: rtl/arith_pkg.sv
// Shared arithmetic-block types: FSM state encoding and default datapath width.
package arith_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor_full_sub.sv
// Gate-level one-bit full subtractor: d = x - y - bin, bout = borrow out.
module full_subtractor (
  input  wire x,
  input  wire y,
  input  wire bin,
  output wire d,
  output wire bout
);
  wire t, xn, tn, g, p;

  xor u_x1 (t, x, y);
  xor u_x2 (d, t, bin);
  not u_n1 (xn, x);
  and u_a1 (g, xn, y);
  // a propagated borrow only survives when x and y agree
  not u_n2 (tn, t);
  and u_a2 (p, tn, bin);
  or  u_o1 (bout, g, p);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin, LSB first, one bit per clock with a registered borrow.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  sub
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh, res, diff_q;
  logic [CNT_W-1:0]   cnt;
  logic               brw, a_msb, b_msb, bout_q, ovf_q;
  logic               d, nb, last;

  full_subtractor u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (brw),
    .d    (d),
    .bout (nb)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sub.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sub.start) begin
          a_sh  <= sub.a;
          b_sh  <= sub.b;
          brw   <= sub.bin;
          cnt   <= '0;
          a_msb <= sub.a[WIDTH-1];
          b_msb <= sub.b[WIDTH-1];
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= {d, res[WIDTH-1:1]};
          brw  <= nb;
          cnt  <= cnt + CNT_W'(1);
          // results only move on the final bit so they never show partial sums
          if (last) begin
            diff_q <= {d, res[WIDTH-1:1]};
            bout_q <= nb;
            ovf_q  <= (a_msb != b_msb) && (d != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign sub.busy = (state != IDLE);
  assign sub.done = (state == DONE);
  assign sub.diff = diff_q;
  assign sub.bout = bout_q;
  assign sub.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random bench for serial_subtractor against an integer-arithmetic model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor_if #(.WIDTH(W)) sif ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sub   (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                                output logic [W-1:0] d, output logic bo, output logic ov);
    int r, s;
    r  = int'(a) - int'(b) - int'(bi);
    d  = r[W-1:0];
    bo = (r < 0);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
    ov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
  endfunction

  // Runs one operation; with inject set, re-pulses start mid-RUN and during DONE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input logic [W-1:0] ed, input logic eb,
                        input logic eo, input bit inject);
    int n;
    logic [W-1:0] prev;
    logic busy_ok, hold_ok;
    @(negedge clk);
    prev = sif.diff;
    sif.start = 1'b1; sif.a = a; sif.b = b; sif.bin = bi;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0; sif.a = $urandom; sif.b = $urandom; sif.bin = 1'b0;
    n = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!sif.done && n < 30) begin
      if (!sif.busy) busy_ok = 1'b0;
      if (sif.diff !== prev) hold_ok = 1'b0;
      if (inject && n == 2) begin sif.start = 1'b1; sif.a = 8'h01; sif.b = 8'h02; end
      if (inject && n == 3) sif.start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, W);
    chk({tag, " busy_run"}, busy_ok, 1'b1);
    chk({tag, " diff_hold"}, hold_ok, 1'b1);
    chk({tag, " diff"}, sif.diff, ed);
    chk({tag, " bout"}, sif.bout, eb);
    chk({tag, " ovf"}, sif.ovf, eo);
    chk({tag, " busy_done"}, sif.busy, 1'b1);
    if (inject) begin sif.start = 1'b1; sif.a = 8'h01; sif.b = 8'h02; end
    @(negedge clk);
    sif.start = 1'b0;
    chk({tag, " done_pulse"}, sif.done, 1'b0);
    chk({tag, " idle"}, sif.busy, 1'b0);
    if (inject) begin
      n = 0;
      repeat (12) begin @(negedge clk); if (sif.done || sif.busy) n++; end
      chk({tag, " no_second_op"}, n, 0);
      chk({tag, " diff_kept"}, sif.diff, ed);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, ed;
    logic rbi, eb, eo;
    sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", sif.busy, 1'b0);
    chk("rst done", sif.done, 1'b0);
    chk("rst diff", sif.diff, 8'h00);
    chk("rst bout", sif.bout, 1'b0);
    chk("rst ovf",  sif.ovf,  1'b0);
    rst_n = 1'b1;

    run_op("5A-3C",   8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);
    run_op("00-01",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("80-01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op("7F-FF",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
    run_op("10-0F-1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op("FF-FF-1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("09-03 ignore", 8'h09, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0, 1'b1);

    // Abort mid-RUN: reset must clear everything asynchronously.
    @(negedge clk);
    sif.start = 1'b1; sif.a = 8'h5A; sif.b = 8'h3C; sif.bin = 1'b0;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", sif.busy, 1'b0);
    chk("abort done", sif.done, 1'b0);
    chk("abort diff", sif.diff, 8'h00);
    chk("abort bout", sif.bout, 1'b0);
    chk("abort ovf",  sif.ovf,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("03-01 post", 8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    repeat (25) begin
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
      model(ra, rb, rbi, ed, eb, eo);
      run_op("rand", ra, rb, rbi, ed, eb, eo, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor that computes A - B - bin one bit per clock, LSB first, using a single registered borrow. It is the subtract-direction counterpart of the team's gate-level full adder. It lets narrow datapaths in later labs trade latency for area. A start/done handshake frames each operation; results are held until the next accepted start.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous, active-low reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  minuend; captured on accepted start
b      input   WIDTH  subtrahend; captured on accepted start
bin    input   1      borrow-in; captured on accepted start
busy   output  1      high in RUN and DONE
done   output  1      one-cycle pulse; result valid
diff   output  WIDTH  difference (a - b - bin) mod 2^WIDTH
bout   output  1      final borrow-out; 1 when a < b + bin, unsigned
ovf    output  1      signed overflow of a - b - bin

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; shift registers, borrow register and counter all cleared.
- IDLE: when start=1 at a clock edge:
  - load a_sh<=a, b_sh<=b, brw<=bin, cnt<=0;
  - go to RUN.
  - With start=0, stay in IDLE; outputs hold the last result.
- RUN, each edge:
  - d = a_sh[0]^b_sh[0]^brw
  - nb = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&brw)
  - shift d into res MSB-side (res <= {d,res[WIDTH-1:1]}); shift a_sh and b_sh right by 1; brw<=nb; cnt<=cnt+1
  - On the edge where cnt==WIDTH-1, the last bit is processed; go to DONE.
  - On that same edge, latch:
    - diff<=final res
    - bout<=nb
    - ovf<=(a_msb!=b_msb)&&(d!=a_msb), where a_msb/b_msb are captured at start.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k → done high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored, with no queuing; a/b/bin changes during RUN have no effect.
- diff/bout/ovf change only on the edge entering DONE, never mid-operation.
- rst_n low mid-RUN aborts immediately: all outputs to reset values, no done pulse.
- Counter is exactly CNT_W bits; no wrap occurs inside RUN. cnt is don't-care outside RUN but is cleared on load.

Decomposition:
- Shared package arith_pkg holds the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the localparam default WIDTH_DEFAULT=8.
- One natural sub-module: full_subtractor (x, y, bin → d, bout), purely combinational and gate-level (xor/and/or primitives), instantiated once in the serial datapath.
- FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
- a=8'h5A, b=8'h3C, bin=0, pulse start → done exactly 8 cycles after the start edge; diff=8'h1E, bout=0, ovf=0.
- a=8'h00, b=8'h01, bin=0 → diff=8'hFF, bout=1, ovf=0.
- a=8'h80, b=8'h01, bin=0 → diff=8'h7F, bout=0, ovf=1. Also a=8'h7F, b=8'hFF → diff=8'h80, bout=1, ovf=1.
- a=8'h10, b=8'h0F, bin=1 → diff=8'h00, bout=0. Then a=8'hFF, b=8'hFF, bin=1 → diff=8'hFF, bout=1.
- Start 8'h09-8'h03, then re-pulse start with a=8'h01, b=8'h02 at cycles 2 and 9 (RUN/DONE) → both ignored; one done only, diff=8'h06, busy stays high throughout.
- Drive rst_n low at cycle 4 of RUN → immediately busy=0, done=0, diff=0, bout=0, ovf=0. Release, start 8'h03-8'h01 → diff=8'h02 after nominal latency.
